// File: rtl/pipe_stage_pkg.sv
// Shared pipeline-stage definitions: state encoding, occupancy width and the
// state-to-handshake decode reused by multi-entry buffers.
package pipe_stage_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    localparam int OCC_W = 2;

    // in_ready drops only when the skid register is occupied.
    function automatic logic state_in_ready(input state_t s);
        return (s != SKID);
    endfunction

    function automatic logic state_out_valid(input state_t s);
        return (s == FULL) || (s == SKID);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// Pipeline register with a valid/ready handshake and a 2-entry skid buffer.
// Every output decodes from flops only, so no input reaches an output combinationally.
module pipe_stage
    import pipe_stage_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
);

    // Handshake: a beat moves on a rising edge where valid and ready are both high.
    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            main_q  <= RESET_VALUE;
            skid_q  <= RESET_VALUE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Squash clears valid state only; data registers keep their contents.
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_valid) begin
                        main_d  = in_data;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (in_valid && out_ready) begin
                        main_d = in_data;
                    end else if (out_ready) begin
                        state_d = EMPTY;
                    end else if (in_valid) begin
                        skid_d  = in_data;
                        state_d = SKID;
                    end
                end
                SKID: begin
                    if (out_ready) begin
                        main_d  = skid_q;
                        state_d = FULL;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    assign in_ready  = state_in_ready(state_q);
    assign out_valid = state_out_valid(state_q);
    assign out_data  = main_q;
    assign occupancy = state_q;

endmodule

// File: doc/pipe_stage.md
Name: pipe_stage

Overview:
Parametrised pipeline register with a valid/ready handshake and a 2-entry skid buffer, for the boundaries between MIPS pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Sustains one beat per cycle under backpressure.
- Registers all outputs.
- Supports a synchronous flush for branch and exception squash.
- Replaces plain enable-gated registers where stall and flush must be handled locally.

Parameters:
WIDTH, 32, payload width in bits (≥1).
RESET_VALUE, 0, value of the data registers on reset (WIDTH bits).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous assert, active-low.
flush  input  1  synchronous squash of all held beats.
in_valid  input  1  upstream beat valid.
in_ready  output  1  stage can accept a beat.
in_data  input  WIDTH  upstream payload.
out_valid  output  1  downstream beat valid.
out_ready  input  1  downstream accepts.
out_data  output  WIDTH  downstream payload (main register).
occupancy  output  2  held beats: 0, 1 or 2.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=EMPTY.
  - main and skid data = RESET_VALUE.
  - out_valid=0, in_ready=1, occupancy=0.
  - Reset mid-transfer discards all held beats.
  - Release is synchronised externally; the block simply leaves reset on the next edge.
- Handshakes:
  - Upstream transfer = in_valid & in_ready at the rising edge.
  - Downstream transfer = out_valid & out_ready at the rising edge.
  - in_valid and in_data may change only after a transfer; the block does not check this.
- Outputs:
  - in_ready, out_valid, out_data and occupancy are registered.
  - No combinational path from any input to any output.
- State machine:
  - EMPTY: out_valid=0, in_ready=1. On in_valid: main<=in_data, go to FULL.
  - FULL: out_valid=1, in_ready=1.
    - in_valid & out_ready: main<=in_data, stay FULL.
    - !in_valid & out_ready: go to EMPTY.
    - in_valid & !out_ready: skid<=in_data, go to SKID.
    - Neither: hold.
  - SKID: out_valid=1, in_ready=0.
    - out_ready: main<=skid, go to FULL.
    - Otherwise hold; in_valid is ignored.
- Latency and throughput:
  - One cycle from upstream transfer to out_valid with empty pipeline.
  - Full throughput (1 beat/cycle) while out_ready=1.
  - A single out_ready=0 cycle is absorbed by the skid register with no bubble on the upstream side in that cycle.
- Ordering: beats leave in acceptance order. Skid is never overwritten while occupied.
- Flush:
  - Next state=EMPTY, out_valid=0, in_ready=1, occupancy=0.
  - Flush has priority over every other event in that cycle.
  - A beat that transfers upstream in the flush cycle is discarded.
  - A downstream transfer in the flush cycle still counts as completed for the consumer.
  - Data registers keep their values; only valid state is cleared.
- Occupancy: EMPTY=0, FULL=1, SKID=2. Tracks the state after each edge.
- Widths: payload is passed through unmodified, with no truncation or extension.

Decomposition:
- Shared pipeline definitions package holds:
  - state encoding localparams: EMPTY=2'd0, FULL=2'd1, SKID=2'd2;
  - occupancy width constant.
- The state-to-in_ready/out_valid decode is shared with the future multi-entry FIFO.
- No sub-module: the datapath is two WIDTH-bit registers plus a 2:1 mux. A separate instance adds nothing.

Test Plan:
1. Reset: hold rst=0 with in_valid=1 and in_data=32'hDEADBEEF, then release. Required: out_valid=0, in_ready=1, out_data=0, occupancy=0 throughout reset. After release, the first edge with in_valid loads the beat, and out_valid=1 with out_data=32'hDEADBEEF on the next cycle.
2. Streaming: in_valid=1 and out_ready=1 for 8 cycles, data 1..8. Required: out_data = 1..8 on consecutive cycles starting one cycle later. in_ready stays 1 and occupancy stays 1.
3. Backpressure:
   - Stream 1,2,3 and drop out_ready for 2 cycles after beat 1 appears.
   - Required: occupancy goes to 2 and in_ready=0 while beat 3 waits.
   - out_data holds 1 during the stall.
   - On out_ready=1, output is 1,2,3 in order, with no loss or duplication.
4. Flush in SKID:
   - Fill to occupancy=2 with beats 10 and 11.
   - Assert flush together with in_valid=1, in_data=12, out_ready=0.
   - Required next cycle: out_valid=0, occupancy=0, in_ready=1.
   - Beat 12 never appears at the output.
5. Flush with simultaneous accept:
   - In FULL with out_ready=1, assert flush together with in_valid=1, in_data=20.
   - Required: the current beat counts as consumed, beat 20 is dropped, and state=EMPTY.
6. Async reset mid-stream:
   - Pull rst low between clock edges while in SKID.
   - Required: out_valid, in_ready and occupancy take their reset values immediately, without waiting for a clock edge.
   - Run with WIDTH=8 and RESET_VALUE=8'hA5: out_data=8'hA5.
